// File: rtl/score_digit_renderer.sv
// ============================================================================
// Module  : score_digit_renderer
// Brief   : Tear-free per-frame capture of a 5-digit BCD score, rasterised
//           from an 8x16 font ROM through a 3-stage pixel pipeline.
//           Optional SCORE_ZERO_BLANK_EN blanks leading zeros.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module score_digit_renderer #(
    parameter logic [9:0] X0         = 10'd560,
    parameter logic [9:0] Y0         = 10'd8,
    parameter logic [3:0] STABLE_CYC = 4'd8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic [19:0] dec_score,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        pixel_valid,
    output logic        score_on,
    output logic        score_valid,
    output logic        locked
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETTLE   = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;
    localparam logic [3:0] GLYPH_BLANK = 4'd10;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] prev_q;
    logic [19:0] shown_q, shown_d;
    logic [4:0]  mask_q, mask_d;
    logic        locked_q, locked_d;
    logic [4:0]  cap_mask;
    logic        same_w;

`ifdef SCORE_ZERO_BLANK_EN
    localparam logic [4:0] MASK_RST = 5'b11110;
    logic zero_run;

    // Digit d is blanked while every digit from the MSD down to d is zero.
    always_comb begin
        zero_run = 1'b1;
        cap_mask = 5'b00000;
        for (int d = 4; d >= 1; d--) begin
            zero_run    = zero_run & (dec_score[4*d +: 4] == 4'd0);
            cap_mask[d] = zero_run;
        end
    end
`else
    localparam logic [4:0] MASK_RST = 5'b00000;
    assign cap_mask = 5'b00000;
`endif

    assign same_w = (dec_score == prev_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shown_d  = shown_q;
        mask_d   = mask_q;
        locked_d = locked_q;
        case (state_q)
            ST_IDLE, ST_LOCKED: begin
                if (frame_start) begin
                    state_d  = ST_SETTLE;
                    cnt_d    = 4'd0;
                    locked_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (frame_start || !same_w) begin
                    cnt_d = 4'd0;
                end else if (cnt_q >= STABLE_CYC) begin
                    // Capture only on a matching sample so the loaded value is the stable one.
                    shown_d  = dec_score;
                    mask_d   = cap_mask;
                    locked_d = 1'b1;
                    state_d  = ST_LOCKED;
                end else if (cnt_q != 4'hF) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            prev_q   <= 20'd0;
            shown_q  <= 20'd0;
            mask_q   <= MASK_RST;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= dec_score;
            shown_q  <= shown_d;
            mask_q   <= mask_d;
            locked_q <= locked_d;
        end
    end

    // Stage 1: field hit test and glyph selection from the current shown set.
    logic signed [10:0] dx_w, dy_w;
    logic               hit_w;
    logic [3:0]         digit_w, glyph_w;
    logic               blank_w;

    assign dx_w  = $signed({1'b0, DrawX}) - $signed({1'b0, X0});
    assign dy_w  = $signed({1'b0, DrawY}) - $signed({1'b0, Y0});
    assign hit_w = pixel_valid && (dx_w >= 11'sd0) && (dx_w < 11'sd40)
                               && (dy_w >= 11'sd0) && (dy_w < 11'sd16);

    always_comb begin
        digit_w = 4'd0;
        blank_w = 1'b1;
        case (dx_w[5:3])
            3'd0: begin digit_w = shown_q[19:16]; blank_w = mask_q[4]; end
            3'd1: begin digit_w = shown_q[15:12]; blank_w = mask_q[3]; end
            3'd2: begin digit_w = shown_q[11:8];  blank_w = mask_q[2]; end
            3'd3: begin digit_w = shown_q[7:4];   blank_w = mask_q[1]; end
            3'd4: begin digit_w = shown_q[3:0];   blank_w = mask_q[0]; end
            default: ;
        endcase
        glyph_w = (blank_w || (digit_w > 4'd9)) ? GLYPH_BLANK : digit_w;
    end

    function automatic logic [7:0] font_row(input logic [3:0] g, input logic [3:0] r);
        logic [127:0] bits;
        case (g)
            4'd0:    bits = 128'h0000_3C66_666E_7666_6666_6666_3C00_0000;
            4'd1:    bits = 128'h0000_1838_7818_1818_1818_1818_7E00_0000;
            4'd2:    bits = 128'h0000_3C66_0606_0C18_3060_6066_7E00_0000;
            4'd3:    bits = 128'h0000_3C66_0606_1C06_0606_0666_3C00_0000;
            4'd4:    bits = 128'h0000_0C1C_3C6C_CCCC_FE0C_0C0C_1E00_0000;
            4'd5:    bits = 128'h0000_7E60_6060_7C06_0606_0666_3C00_0000;
            4'd6:    bits = 128'h0000_1C30_6060_7C66_6666_6666_3C00_0000;
            4'd7:    bits = 128'h0000_7E66_0606_0C18_1818_1818_1800_0000;
            4'd8:    bits = 128'h0000_3C66_6666_3C66_6666_6666_3C00_0000;
            4'd9:    bits = 128'h0000_3C66_6666_663E_0606_060C_3800_0000;
            default: bits = 128'h0;
        endcase
        return bits[{~r, 3'b000} +: 8];
    endfunction

    logic       s1_hit_q, s1_pv_q;
    logic [3:0] s1_glyph_q, s1_row_q;
    logic [2:0] s1_col_q;
    logic       s2_hit_q, s2_pv_q;
    logic [2:0] s2_col_q;
    logic [7:0] s2_rom_q;
    logic       s3_on_q, s3_pv_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1_hit_q   <= 1'b0;
            s1_pv_q    <= 1'b0;
            s1_glyph_q <= GLYPH_BLANK;
            s1_row_q   <= 4'd0;
            s1_col_q   <= 3'd0;
            s2_hit_q   <= 1'b0;
            s2_pv_q    <= 1'b0;
            s2_col_q   <= 3'd0;
            s2_rom_q   <= 8'd0;
            s3_on_q    <= 1'b0;
            s3_pv_q    <= 1'b0;
        end else begin
            s1_hit_q   <= hit_w;
            s1_pv_q    <= pixel_valid;
            s1_glyph_q <= glyph_w;
            s1_row_q   <= dy_w[3:0];
            s1_col_q   <= dx_w[2:0];
            s2_hit_q   <= s1_hit_q;
            s2_pv_q    <= s1_pv_q;
            s2_col_q   <= s1_col_q;
            s2_rom_q   <= font_row(s1_glyph_q, s1_row_q);
            s3_on_q    <= s2_hit_q & s2_rom_q[3'd7 - s2_col_q];
            s3_pv_q    <= s2_pv_q;
        end
    end

    assign score_on    = s3_on_q;
    assign score_valid = s3_pv_q;
    assign locked      = locked_q;

endmodule

`default_nettype wire

// File: tb/tb_score_digit_renderer.sv
// ============================================================================
// Module  : tb_score_digit_renderer
// Brief   : Randomised self-checking bench for score_digit_renderer against a
//           behavioural frame/pixel model (honours SCORE_ZERO_BLANK_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_digit_renderer;

    localparam int X0         = 560;
    localparam int Y0         = 8;
    localparam int STABLE_CYC = 8;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_start = 1'b0;
    logic [19:0] dec_score = 20'd0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic        pixel_valid = 1'b0;
    logic        score_on, score_valid, locked;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    score_digit_renderer #(
        .X0(10'(X0)), .Y0(10'(Y0)), .STABLE_CYC(4'(STABLE_CYC))
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .dec_score(dec_score),
        .DrawX(DrawX), .DrawY(DrawY), .pixel_valid(pixel_valid),
        .score_on(score_on), .score_valid(score_valid), .locked(locked)
    );

    always #5 Clk = ~Clk;

    // ---------------- behavioural model ----------------
    logic [127:0] font [0:9];
    logic [3:0]   m_shown [5];
    bit           m_mask  [5];
    bit           m_settling, m_locked;
    int           m_repeats;      // consecutive cycles the score equalled its previous sample
    logic [19:0]  m_prev;
    bit           exp_on  [3];
    bit           exp_val [3];

    task automatic set_shown(input logic [19:0] v);
        bit z;
        for (int d = 0; d < 5; d++) begin
            m_shown[d] = v[4*d +: 4];
            m_mask[d]  = 1'b0;
        end
`ifdef SCORE_ZERO_BLANK_EN
        z = 1'b1;
        for (int d = 4; d >= 1; d--) begin
            z = z && (m_shown[d] == 4'd0);
            m_mask[d] = z;
        end
`else
        z = 1'b0;
        m_mask[0] = z;
`endif
    endtask

    function automatic bit pixel_exp(input int x, input int y, input bit pv);
        int dx, dy, d;
        logic [3:0] g;
        dx = x - X0;
        dy = y - Y0;
        if (!pv || dx < 0 || dx >= 40 || dy < 0 || dy >= 16) return 1'b0;
        d = 4 - dx / 8;
        g = m_shown[d];
        if (m_mask[d] || g > 4'd9) return 1'b0;
        return font[g][127 - 8*dy - dx % 8];
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_settling = 1'b0;
            m_locked   = 1'b0;
            m_repeats  = 0;
            m_prev     = 20'd0;
            set_shown(20'd0);
            for (int i = 0; i < 3; i++) begin exp_on[i] = 1'b0; exp_val[i] = 1'b0; end
        end else begin
            exp_on[2]  = exp_on[1];  exp_on[1]  = exp_on[0];
            exp_val[2] = exp_val[1]; exp_val[1] = exp_val[0];
            exp_on[0]  = pixel_exp(int'(DrawX), int'(DrawY), pixel_valid);
            exp_val[0] = pixel_valid;
            if (frame_start) begin
                m_settling = 1'b1;
                m_repeats  = 0;
                m_locked   = 1'b0;
            end else if (m_settling) begin
                if (dec_score != m_prev) m_repeats = 0;
                else if (m_repeats >= STABLE_CYC) begin
                    set_shown(dec_score);
                    m_locked   = 1'b1;
                    m_settling = 1'b0;
                end else m_repeats++;
            end
            m_prev = dec_score;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            check("score_on",    32'(score_on),    32'(exp_on[2]));
            check("score_valid", 32'(score_valid), 32'(exp_val[2]));
            check("locked",      32'(locked),      32'(m_locked));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_frame;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
    endtask

    task automatic wait_lock(input int max, output int n);
        n = 0;
        while (!locked && n < max) begin
            tick;
            n++;
        end
        check("lock_timeout", 32'(locked), 32'd1);
    endtask

    task automatic probe(input string nm, input int x, input int y, input bit expv);
        DrawX = 10'(x);
        DrawY = 10'(y);
        pixel_valid = 1'b1;
        tick; tick; tick;
        check(nm, 32'(score_on), 32'(expv));
        pixel_valid = 1'b0;
    endtask

    task automatic rand_pixel;
        if ($urandom_range(0, 15) == 0) begin
            DrawX = 10'($urandom_range(0, 1023));
            DrawY = 10'($urandom_range(0, 1023));
        end else begin
            DrawX = 10'(X0 - 8 + int'($urandom_range(0, 55)));
            DrawY = 10'(Y0 - 4 + int'($urandom_range(0, 23)));
        end
        pixel_valid = ($urandom_range(0, 7) != 0);
    endtask

    function automatic logic [19:0] rand_score();
        logic [19:0] v;
        for (int d = 0; d < 5; d++)
            v[4*d +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    task automatic scan_random(input int n);
        for (int i = 0; i < n; i++) begin rand_pixel(); tick; end
    endtask

    task automatic reset_pulse(input string nm);
        @(posedge Clk);
        #3;
        Reset = 1'b0;
        #1;
        check({nm, "_on"},     32'(score_on),    32'd0);
        check({nm, "_valid"},  32'(score_valid), 32'd0);
        check({nm, "_locked"}, 32'(locked),      32'd0);
        tick; tick;
        Reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [19:0] v;
        font[0] = 128'h0000_3C66_666E_7666_6666_6666_3C00_0000;
        font[1] = 128'h0000_1838_7818_1818_1818_1818_7E00_0000;
        font[2] = 128'h0000_3C66_0606_0C18_3060_6066_7E00_0000;
        font[3] = 128'h0000_3C66_0606_1C06_0606_0666_3C00_0000;
        font[4] = 128'h0000_0C1C_3C6C_CCCC_FE0C_0C0C_1E00_0000;
        font[5] = 128'h0000_7E60_6060_7C06_0606_0666_3C00_0000;
        font[6] = 128'h0000_1C30_6060_7C66_6666_6666_3C00_0000;
        font[7] = 128'h0000_7E66_0606_0C18_1818_1818_1800_0000;
        font[8] = 128'h0000_3C66_6666_3C66_6666_6666_3C00_0000;
        font[9] = 128'h0000_3C66_6666_663E_0606_060C_3800_0000;

        repeat (3) tick;
        chk_en = 1'b1;
        Reset  = 1'b1;

        // Idle after reset: nothing lit, nothing locked.
        for (int i = 0; i < 100; i++) begin
            dec_score = rand_score();
            tick;
            check("idle_on", 32'(score_on), 32'd0);
            check("idle_locked", 32'(locked), 32'd0);
        end
        probe("rst_units_0", X0 + 34, Y0 + 2, 1'b1);
`ifdef SCORE_ZERO_BLANK_EN
        probe("rst_msd", X0 + 2, Y0 + 2, 1'b0);
`else
        probe("rst_msd", X0 + 2, Y0 + 2, 1'b1);
`endif
        scan_random(100);

        // Static 01234: exact lock latency and the '4' cell.
        dec_score = 20'h01234;
        tick; tick;
        pulse_frame;
        wait_lock(30, n);
        check("lock_latency", 32'(n), 32'(STABLE_CYC + 1));
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 8; x++) begin
                DrawX = 10'(X0 + 32 + x); DrawY = 10'(Y0 + y); pixel_valid = 1'b1;
                tick;
            end
        probe("glyph4_r8c0", X0 + 32, Y0 + 8, 1'b1);
        probe("glyph4_r8c7", X0 + 39, Y0 + 8, 1'b0);
        probe("glyph1_r12c1", X0 + 9, Y0 + 12, 1'b1);

        // Churning score: no capture until it holds.
        v = dec_score;
        frame_start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) begin
                v = v ^ 20'($urandom_range(1, 20'hFFFFF));
                if (v == 20'h99999) v = 20'h12345;
                dec_score = v;
            end
            rand_pixel();
            tick;
            frame_start = 1'b0;
        end
        check("churn_locked", 32'(locked), 32'd0);
        dec_score = 20'h99999;
        wait_lock(40, n);
        check("hold_latency", 32'(n), 32'(STABLE_CYC + 2));
        probe("glyph9_r7c2", X0 + 2, Y0 + 7, 1'b1);
        probe("glyph9_r7c0", X0 + 0, Y0 + 7, 1'b0);
        scan_random(150);

        // Leading zeros.
        dec_score = 20'h00042;
        pulse_frame;
        wait_lock(30, n);
`ifdef SCORE_ZERO_BLANK_EN
        probe("lead0_d2", X0 + 18, Y0 + 2, 1'b0);
`else
        probe("lead0_d2", X0 + 18, Y0 + 2, 1'b1);
`endif
        probe("d1_is_4", X0 + 24, Y0 + 8, 1'b1);
        scan_random(150);

        // Non-BCD digit renders blank.
        dec_score = 20'h1C357;
        pulse_frame;
        wait_lock(30, n);
        probe("digitC_blank", X0 + 10, Y0 + 2, 1'b0);
        probe("d4_is_1", X0 + 3, Y0 + 4, 1'b1);
        scan_random(150);

        // Random frames, scores and scans.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) dec_score = rand_score();
            frame_start = ($urandom_range(0, 199) == 0);
            rand_pixel();
            tick;
        end
        frame_start = 1'b0;

        // Reset mid-scan with a lit pixel in flight, then during SETTLE.
        dec_score = 20'h55555;
        pulse_frame;
        wait_lock(30, n);
        probe("pre_reset_on", X0 + 33, Y0 + 2, 1'b1);
        pixel_valid = 1'b1;
        reset_pulse("rst_scan");
        pulse_frame;
        tick; tick; tick;
        reset_pulse("rst_settle");
        pulse_frame;
        wait_lock(30, n);
        check("relock_latency", 32'(n), 32'(STABLE_CYC + 1));
        probe("post_reset_5", X0 + 33, Y0 + 2, 1'b1);
        scan_random(50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
